// File: rtl/image_pkg.sv
// Shared types and constants for the image write controller: FSM states,
// pair channel layout and default frame geometry.
package image_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_WAIT_WR
  } state_e;

  localparam int CH_W   = 8;
  localparam int PAIR_W = 6 * CH_W;

  // Bit offsets of each channel inside in_pair ({R0,G0,B0,R1,G1,B1}, R0 on top)
  localparam int OFF_R0 = 5 * CH_W;
  localparam int OFF_G0 = 4 * CH_W;
  localparam int OFF_B0 = 3 * CH_W;
  localparam int OFF_R1 = 2 * CH_W;
  localparam int OFF_G1 = 1 * CH_W;
  localparam int OFF_B1 = 0;

  localparam int DEF_WIDTH  = 768;
  localparam int DEF_HEIGHT = 512;
  localparam int DEF_HBLANK = 160;

  function automatic int pairs_per_frame(input int width, input int height);
    return (width / 2) * height;
  endfunction

endpackage

// File: rtl/blank_timer.sv
// Loadable down-counter with a zero flag; times the horizontal blanking gap.
// Holds at zero once expired; clr forces it back to zero.
module blank_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/image_write_ctrl.sv
// Frame sequencer: accepts pixel pairs from the pipeline, replays them to the
// BMP writer as HSYNC + six channels, with row blanking and frame completion.
module image_write_ctrl
  import image_pkg::*;
#(
  parameter int  WIDTH  = DEF_WIDTH,
  parameter int  HEIGHT = DEF_HEIGHT,
  parameter int  HBLANK = DEF_HBLANK,
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int COL_W  = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PAIR_W-1:0] in_pair,
  output logic              HSYNC,
  output logic [CH_W-1:0]   DATA_WRITE_R0,
  output logic [CH_W-1:0]   DATA_WRITE_G0,
  output logic [CH_W-1:0]   DATA_WRITE_B0,
  output logic [CH_W-1:0]   DATA_WRITE_R1,
  output logic [CH_W-1:0]   DATA_WRITE_G1,
  output logic [CH_W-1:0]   DATA_WRITE_B1,
  input  logic              write_done,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              busy,
  output logic              frame_done,
  output logic              aborted
);

  localparam int                TMR_W    = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH / 2 - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(HBLANK - 1);

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic                hsync_q, hsync_d;
  logic                frame_done_q, frame_done_d;
  logic                aborted_q, aborted_d;
  logic                tmr_load, tmr_clr, tmr_zero;

  blank_timer #(
    .CNT_W (TMR_W)
  ) u_blank_timer (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .load_i     (tmr_load),
    .clr_i      (tmr_clr),
    .load_val_i (TMR_LOAD),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    pair_d       = pair_q;
    hsync_d      = 1'b0;
    frame_done_d = 1'b0;
    aborted_d    = 1'b0;
    tmr_load     = 1'b0;
    tmr_clr      = 1'b0;

    // Abort outranks any transfer, blank expiry or write completion
    if (state_q != ST_IDLE && abort) begin
      state_d   = ST_IDLE;
      row_d     = '0;
      col_d     = '0;
      tmr_clr   = 1'b1;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ACTIVE;
            row_d   = '0;
            col_d   = '0;
          end
        end
        ST_ACTIVE: begin
          if (in_valid) begin
            hsync_d = 1'b1;
            pair_d  = in_pair;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                state_d = ST_WAIT_WR;
              end else begin
                row_d    = row_q + ROW_W'(1);
                state_d  = ST_HBLANK;
                tmr_load = 1'b1;
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        ST_HBLANK: begin
          if (tmr_zero) begin
            state_d = ST_ACTIVE;
          end
        end
        ST_WAIT_WR: begin
          if (write_done) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      pair_q       <= '0;
      hsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pair_q       <= pair_d;
      hsync_q      <= hsync_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign in_ready      = (state_q == ST_ACTIVE);
  assign busy          = (state_q != ST_IDLE);
  assign row           = row_q;
  assign col           = col_q;
  assign HSYNC         = hsync_q;
  assign frame_done    = frame_done_q;
  assign aborted       = aborted_q;
  assign DATA_WRITE_R0 = pair_q[OFF_R0 +: CH_W];
  assign DATA_WRITE_G0 = pair_q[OFF_G0 +: CH_W];
  assign DATA_WRITE_B0 = pair_q[OFF_B0 +: CH_W];
  assign DATA_WRITE_R1 = pair_q[OFF_R1 +: CH_W];
  assign DATA_WRITE_G1 = pair_q[OFF_G1 +: CH_W];
  assign DATA_WRITE_B1 = pair_q[OFF_B1 +: CH_W];

endmodule
